// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem req/ack fetch, prefetch queue, decode-side valid/stall outputs.
// Define IF_BYPASS_EN to forward an acked word straight to the if_* outputs when the queue is empty.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [5:0]        if_op,
  output logic [5:0]        if_func
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [31:0]       q_instr [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              q_empty;
  logic              xfer;
  logic              push;
  logic              pop;

  // Request is held off during reset, while full, and in any redirect cycle.
  assign q_empty   = (count == '0);
  assign imem_req  = reset_n && (count < FULL_CNT) && !redirect;
  assign imem_addr = fetch_pc;
  assign xfer      = imem_req && imem_ack;

`ifdef IF_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = q_empty && xfer;
  assign if_valid   = !q_empty || bypass_hit;
  assign pop        = !q_empty && !stall;
  assign push       = xfer && !(bypass_hit && !stall);

  always_comb begin
    if_instr = '0;
    if_pc    = '0;
    if (bypass_hit) begin
      if_instr = imem_rdata;
      if_pc    = fetch_pc;
    end else if (!q_empty) begin
      if_instr = q_instr[rd_ptr];
      if_pc    = q_pc[rd_ptr];
    end
  end
`else
  assign if_valid = !q_empty;
  assign pop      = if_valid && !stall;
  assign push     = xfer;

  always_comb begin
    if_instr = '0;
    if_pc    = '0;
    if (!q_empty) begin
      if_instr = q_instr[rd_ptr];
      if_pc    = q_pc[rd_ptr];
    end
  end
`endif

  assign if_op   = if_instr[31:26];
  assign if_func = if_instr[5:0];

  // Redirect outranks everything: it flushes the queue and drops this cycle's push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (xfer) fetch_pc <= fetch_pc + ADDR_W'(4);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: randomized and directed traffic against a queue-based model.
module tb_instr_fetch;

  localparam int          ADDR_W   = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              reset_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [5:0]        if_op;
  logic [5:0]        if_func;

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_op(if_op), .if_func(if_func)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  // Reference model: expected fetch address plus a queue of pending {pc, instr}.
  logic [31:0]  mpc;
  logic [31:0]  mq_pc[$];
  logic [31:0]  mq_instr[$];
  logic         e_req;
  logic         e_xfer;
  logic [109:0] e_vec;
  logic [109:0] o_vec;

  function automatic logic [109:0] pack(input logic req, input logic [31:0] addr, input logic v,
                                        input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [5:0] op, input logic [5:0] fn);
    return {req, (req ? addr : 32'h0), v, ins, pc, op, fn};
  endfunction

  function automatic logic [109:0] observe();
    return pack(imem_req, imem_addr, if_valid, if_instr, if_pc, if_op, if_func);
  endfunction

  task automatic model_reset();
    mpc = RESET_PC;
    mq_pc.delete();
    mq_instr.delete();
  endtask

  task automatic model_eval();
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    e_req  = (mq_pc.size() < DEPTH) && !redirect;
    e_xfer = e_req && imem_ack;
    if (mq_pc.size() != 0) begin
      v = 1'b1; ins = mq_instr[0]; pc = mq_pc[0];
    end else if (BYPASS && e_xfer) begin
      v = 1'b1; ins = imem_rdata; pc = mpc;
    end else begin
      v = 1'b0; ins = 32'h0; pc = 32'h0;
    end
    e_vec = pack(e_req, mpc, v, ins, pc, ins[31:26], ins[5:0]);
  endtask

  task automatic model_commit();
    if (redirect) begin
      mq_pc.delete();
      mq_instr.delete();
      mpc = redirect_pc & 32'hFFFF_FFFC;
    end else if (BYPASS && mq_pc.size() == 0 && e_xfer && !stall) begin
      mpc = mpc + 32'd4;
    end else begin
      if (mq_pc.size() != 0 && !stall) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (e_xfer) begin
        mq_pc.push_back(mpc);
        mq_instr.push_back(imem_rdata);
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                       input logic rd, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    o_vec = observe();
    n_cmp++;
    if (o_vec !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got %h need %h", o_vec, 110'h0);
    end
    reset_n = 1'b1;
    model_reset();
    drive(1'b1, 32'h1111_0000, 1'b1, 1'b0, 32'h0);
    model_eval();
    @(negedge clk);
    o_vec = observe();
    n_cmp++;
    if (o_vec !== e_vec) begin
      n_fail++;
      $display("[TB] FAIL reset_first: got %h need %h", o_vec, e_vec);
    end
    model_commit();
    @(posedge clk); #1;
    drive(1'b1, 32'h2222_0000, 1'b1, 1'b0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    o_vec = observe();
    n_cmp++;
    if (o_vec !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: got %h need %h", o_vec, 110'h0);
    end
    #1 reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h3333_0000 + i, 1'b0, 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL reset_restart cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 32'(4 * i)) begin
        n_fail++;
        $display("[TB] FAIL reset_addr cyc %0d: got req=%b addr=%h need req=1 addr=%h",
                 i, imem_req, imem_addr, RESET_PC + 32'(4 * i));
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stream();
    int lat;
    lat = BYPASS ? 0 : 1;
    for (int i = -1; i < 14; i++) begin
      if (i < 0)
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      else if (i < 12)
        drive(1'b1, 32'h2008_0001 + 32'(i) * 32'h0001_0001, 1'b0, 1'b0, 32'h0);
      else
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL stream cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      if (i == lat) begin
        n_cmp++;
        if (if_instr !== 32'h2008_0001 || if_op !== 6'h08 || if_pc !== 32'h0 || if_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stream_first: got v=%b instr=%h op=%h pc=%h need v=1 instr=20080001 op=08 pc=0",
                   if_valid, if_instr, if_op, if_pc);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_stall();
    int pushes;
    int drained;
    pushes  = 0;
    drained = 0;
    for (int i = -1; i < 5 + DEPTH + 2; i++) begin
      if (i < 0)
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
      else if (i < 5)
        drive(1'b1, 32'hA000_0000 + i, 1'b1, 1'b0, 32'h0);
      else
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL full_stall cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      if (i >= 0 && i < 5 && imem_req && imem_ack) pushes++;
      if (i >= 5 && if_valid) drained++;
      model_commit();
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pushes != DEPTH || drained != DEPTH) begin
      n_fail++;
      $display("[TB] FAIL full_count: got pushes=%0d drained=%0d need %0d each", pushes, drained, DEPTH);
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < DEPTH + 5; i++) begin
      if (i < DEPTH + 1)
        drive(1'b1, 32'hB000_0000 + i, 1'b1, 1'b0, 32'h0);
      else if (i == DEPTH + 1)
        drive(1'b1, 32'hBAD0_0BAD, 1'b1, 1'b1, 32'h0000_0103);
      else
        drive(1'b1, 32'hC000_0000 + i, 1'b0, 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL redirect cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      if (i == DEPTH + 2) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || (!BYPASS && if_valid !== 1'b0)) begin
          n_fail++;
          $display("[TB] FAIL redirect_target: got req=%b addr=%h v=%b need req=1 addr=00000100",
                   imem_req, imem_addr, if_valid);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    for (int i = -1; i < 5; i++) begin
      if (i < 0)
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      else if (i < 2)
        drive(1'b1, 32'hD000_0000 + i, 1'b1, 1'b0, 32'h0);
      else
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL wrap cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      if (i >= 0 && i < 2) begin
        want = (i == 0) ? 32'hFFFF_FFFC : 32'h0000_0000;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== want) begin
          n_fail++;
          $display("[TB] FAIL wrap_addr cyc %0d: got req=%b addr=%h need req=1 addr=%h",
                   i, imem_req, imem_addr, want);
        end
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_slow_random();
    for (int i = 0; i < 60; i++) begin
      drive((i % 3) == 2, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL slow_mem cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 8, $urandom);
      model_eval();
      @(negedge clk);
      o_vec = observe();
      n_cmp++;
      if (o_vec !== e_vec) begin
        n_fail++;
        $display("[TB] FAIL back_to_back cyc %0d: got %h need %h", i, o_vec, e_vec);
      end
      model_commit();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    model_reset();
    $display("[TB] instr_fetch bench start (bypass=%0d)", BYPASS);
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_wrap();
    test_slow_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
